// File: rtl/skip_pkg.sv
// Shared constants and per-stage control payload for the carry-skip pipeline.
package skip_pkg;

  localparam int SLICE_W = 4;

  // Control fields that travel with a beat; the data fields (a_hi, b_hi, sum_lo)
  // depend on WIDTH and live beside this struct in each stage.
  typedef struct packed {
    logic vld;
    logic acc;
    logic carry;
  } stg_ctrl_t;

endpackage

// File: rtl/skip_stage.sv
// One pipeline stage: SLICE_W-bit carry-skip add of slice IDX plus the payload register.
module skip_stage
  import skip_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int IDX   = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             rdy,
  input  logic             in_vld,
  input  logic             in_acc,
  input  logic             in_carry,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_sum,
  output logic             out_vld,
  output logic             out_acc,
  output logic             out_carry,
  output logic [WIDTH-1:0] out_a,
  output logic [WIDTH-1:0] out_b,
  output logic [WIDTH-1:0] out_sum
);

  localparam int LO = IDX * SLICE_W;

  logic [SLICE_W-1:0] a_sl, b_sl, s_sl;
  logic [SLICE_W:0]   c;
  logic               prop_all;
  logic               carry_next;
  logic [WIDTH-1:0]   sum_next;

  stg_ctrl_t          ctrl_reg;
  logic [WIDTH-1:0]   a_reg, b_reg, sum_reg;

  assign a_sl = in_a[LO +: SLICE_W];
  assign b_sl = in_b[LO +: SLICE_W];
  assign c[0] = in_carry;

  for (genvar gi = 0; gi < SLICE_W; gi++) begin : g_bit
    assign s_sl[gi]  = a_sl[gi] ^ b_sl[gi] ^ c[gi];
    assign c[gi+1]   = (a_sl[gi] & b_sl[gi]) | ((a_sl[gi] ^ b_sl[gi]) & c[gi]);
  end

  // Skip path: when every bit propagates, the carry-in bypasses the ripple chain.
  assign prop_all   = &(a_sl ^ b_sl);
  assign carry_next = prop_all ? in_carry : c[SLICE_W];

  // Bits at and above this slice are still zero in in_sum, so OR-ing inserts the slice.
  assign sum_next   = in_sum | (WIDTH'(s_sl) << LO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_reg <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      sum_reg  <= '0;
    end else if (rdy) begin
      ctrl_reg.vld <= in_vld;
      if (in_vld) begin
        ctrl_reg.acc   <= in_acc;
        ctrl_reg.carry <= carry_next;
        a_reg          <= in_a;
        b_reg          <= in_b;
        sum_reg        <= sum_next;
      end
    end
  end

  assign out_vld   = ctrl_reg.vld;
  assign out_acc   = ctrl_reg.acc;
  assign out_carry = ctrl_reg.carry;
  assign out_a     = a_reg;
  assign out_b     = b_reg;
  assign out_sum   = sum_reg;

endmodule

// File: rtl/skip_acc_pipe.sv
// Pipelined valid/ready carry-skip adder with optional accumulate mode.
// Define SKIP_ACC_SAT_EN to saturate out_sum and the accumulator on top carry.
module skip_acc_pipe
  import skip_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_ci,
  input  logic             in_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_co,
  output logic [WIDTH-1:0] acc_q
);

  localparam int NSTG = WIDTH / SLICE_W;

  if ((WIDTH % SLICE_W) != 0 || WIDTH < SLICE_W) begin : g_width_chk
    $error("skip_acc_pipe: WIDTH must be a nonzero multiple of SLICE_W");
  end

  logic [NSTG-1:0]  stg_vld, stg_acc, stg_rdy;
  logic             carry_c [NSTG+1];
  logic [WIDTH-1:0] a_c     [NSTG+1];
  logic [WIDTH-1:0] b_c     [NSTG+1];
  logic [WIDTH-1:0] sum_c   [NSTG+1];

  logic             acc_inflight, acc_block, s0_vld, out_hs;
  logic [WIDTH-1:0] acc_reg, acc_next, sum_final;
  logic             unused_tail;

  always_comb begin
    acc_inflight = 1'b0;
    for (int k = 0; k < NSTG; k++) acc_inflight = acc_inflight | (stg_vld[k] & stg_acc[k]);
  end

  // Only accumulate beats wait for the feedback value; plain beats flow freely.
  assign acc_block  = in_acc & acc_inflight;
  assign in_ready   = stg_rdy[0] & ~acc_block;
  assign s0_vld     = in_valid & ~acc_block;

  assign carry_c[0] = in_ci;
  assign a_c[0]     = in_acc ? acc_reg : in_a;
  assign b_c[0]     = in_b;
  assign sum_c[0]   = '0;

  for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
    logic vld_i, acc_i;

    if (gi == 0) begin : g_first
      assign vld_i = s0_vld;
      assign acc_i = in_acc;
    end else begin : g_rest
      assign vld_i = stg_vld[gi-1];
      assign acc_i = stg_acc[gi-1];
    end

    // Unrolled form of rdy_k = !vld_k | rdy_(k+1), computed from registered valids only.
    assign stg_rdy[gi] = out_ready | ~(&stg_vld[NSTG-1:gi]);

    skip_stage #(.WIDTH(WIDTH), .IDX(gi)) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .rdy       (stg_rdy[gi]),
      .in_vld    (vld_i),
      .in_acc    (acc_i),
      .in_carry  (carry_c[gi]),
      .in_a      (a_c[gi]),
      .in_b      (b_c[gi]),
      .in_sum    (sum_c[gi]),
      .out_vld   (stg_vld[gi]),
      .out_acc   (stg_acc[gi]),
      .out_carry (carry_c[gi+1]),
      .out_a     (a_c[gi+1]),
      .out_b     (b_c[gi+1]),
      .out_sum   (sum_c[gi+1])
    );
  end

  assign unused_tail = ^{a_c[NSTG], b_c[NSTG]};

`ifdef SKIP_ACC_SAT_EN
  assign sum_final = carry_c[NSTG] ? '1 : sum_c[NSTG];
`else
  assign sum_final = sum_c[NSTG];
`endif

  assign out_valid = stg_vld[NSTG-1];
  assign out_sum   = sum_final;
  assign out_co    = carry_c[NSTG];
  assign out_hs    = out_valid & out_ready;

  // Clear has priority over the write-back of a retiring accumulate beat.
  always_comb begin
    acc_next = acc_reg;
    if (acc_clr)                             acc_next = '0;
    else if (out_hs && stg_acc[NSTG-1])      acc_next = sum_final;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_reg <= '0;
    else        acc_reg <= acc_next;
  end

  assign acc_q = acc_reg;

endmodule

// File: tb/tb_skip_acc_pipe.sv
// Directed, table-driven bench for skip_acc_pipe at WIDTH=8 (two stages).
module tb_skip_acc_pipe;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       in_valid, in_ready, in_ci, in_acc, acc_clr;
  logic [7:0] in_a, in_b;
  logic       out_valid, out_ready, out_co;
  logic [7:0] out_sum, acc_q;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  skip_acc_pipe #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_ci     (in_ci),
    .in_acc    (in_acc),
    .acc_clr   (acc_clr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_co    (out_co),
    .acc_q     (acc_q)
  );

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic       ci;
    logic [7:0] sum;
    logic       co;
  } vec_t;

  function automatic logic [7:0] sat8(input logic [7:0] s, input logic co);
`ifdef SKIP_ACC_SAT_EN
    return co ? 8'hFF : s;
`else
    return s;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end else begin
      $display("ok   %s = %0h", name, act);
    end
  endtask

  task automatic send(input logic [7:0] a, input logic [7:0] b, input logic ci, input logic acc);
    int w;
    @(negedge clk);
    in_valid = 1'b1; in_a = a; in_b = b; in_ci = ci; in_acc = acc;
    #1;
    w = 0;
    while (!in_ready && w < 20) begin
      @(negedge clk); #1; w++;
    end
    if (!in_ready) chk("send_timeout", 32'(in_ready), 1);
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_acc = 1'b0;
  endtask

  task automatic expect_out(input string name, input logic [7:0] es, input logic eco, input int lat);
    int w;
    @(negedge clk);
    w = 1;
    while (!out_valid && w < 20) begin
      @(negedge clk); w++;
    end
    chk({name, "_valid"}, 32'(out_valid), 1);
    if (lat > 0) chk({name, "_latency"}, 32'(w), 32'(lat));
    chk({name, "_sum"}, 32'(out_sum), 32'(es));
    chk({name, "_co"}, 32'(out_co), 32'(eco));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[8];
    logic [7:0] acc_b[3];
    logic [7:0] acc_exp[3];
    int sent, got, stale, w;

    vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
    vecs[1] = '{8'hFF, 8'h00, 1'b1, 8'h00, 1'b1};
    vecs[2] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0};
    vecs[3] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
    vecs[4] = '{8'h7F, 8'h01, 1'b1, 8'h81, 1'b0};
    vecs[5] = '{8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1};
    vecs[6] = '{8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0};
    vecs[7] = '{8'h08, 8'h08, 1'b0, 8'h10, 1'b0};
    acc_b   = '{8'h10, 8'h20, 8'h30};
    acc_exp = '{8'h10, 8'h30, 8'h60};

    rst_n = 1'b0; in_valid = 1'b0; in_a = '0; in_b = '0; in_ci = 1'b0;
    in_acc = 1'b0; acc_clr = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_out_sum", 32'(out_sum), 0);
    chk("rst_out_co", 32'(out_co), 0);
    chk("rst_acc_q", 32'(acc_q), 0);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);

    // Single beats through the table; first one also checks the 2-cycle latency.
    for (int i = 0; i < 8; i++) begin
      send(vecs[i].a, vecs[i].b, vecs[i].ci, 1'b0);
      expect_out($sformatf("vec%0d", i), sat8(vecs[i].sum, vecs[i].co), vecs[i].co,
                 (i == 0) ? 2 : 0);
    end

    // Four back-to-back beats against a 4-cycle output stall.
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 4; cyc++) begin
      @(negedge clk);
      out_ready = (cyc >= 4);
      in_valid  = (sent < 4);
      in_a      = 8'(sent + 1);
      in_b      = 8'(sent + 1);
      in_ci     = 1'b0;
      in_acc    = 1'b0;
      #1;
      if (cyc == 2) chk("stall_in_ready_low", 32'(in_ready), 0);
      if (cyc == 3) chk("stall_hold_sum", 32'(out_sum), 2);
      if (out_valid && out_ready) begin
        chk($sformatf("stall_order%0d", got), 32'(out_sum), 32'(2 * (got + 1)));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    chk("stall_count", 32'(got), 4);

    // Accumulate chain after a clear; A input must be ignored.
    @(negedge clk); acc_clr = 1'b1;
    @(negedge clk); acc_clr = 1'b0;
    sent = 0; got = 0;
    for (int cyc = 0; cyc < 40 && got < 3; cyc++) begin
      @(negedge clk);
      in_valid = (sent < 3);
      in_acc   = 1'b1;
      in_a     = 8'hAA;
      in_b     = (sent < 3) ? acc_b[sent] : 8'h00;
      in_ci    = 1'b0;
      #1;
      if (cyc == 1) chk("acc_interlock", 32'(in_ready), 0);
      if (out_valid && out_ready) begin
        chk($sformatf("acc_sum%0d", got), 32'(out_sum), 32'(acc_exp[got]));
        got++;
      end
      if (in_valid && in_ready) sent++;
    end
    in_valid = 1'b0; in_acc = 1'b0;
    @(negedge clk);
    chk("acc_q_final", 32'(acc_q), 8'h60);

    // Accumulate beat accepted together with a clear uses the old accumulator.
    @(negedge clk);
    acc_clr = 1'b1; in_valid = 1'b1; in_acc = 1'b1; in_a = 8'h00; in_b = 8'h01;
    #1;
    chk("clr_acc_ready", 32'(in_ready), 1);
    @(posedge clk); #1;
    acc_clr = 1'b0; in_valid = 1'b0; in_acc = 1'b0;
    @(negedge clk);
    chk("clr_applied", 32'(acc_q), 0);
    w = 0;
    while (!out_valid && w < 20) begin
      @(negedge clk); w++;
    end
    chk("preclr_sum", 32'(out_sum), 8'h61);
    // Clear lands on the same edge as this beat's output handshake.
    acc_clr = 1'b1;
    @(posedge clk); #1;
    acc_clr = 1'b0;
    @(negedge clk);
    chk("clr_wins", 32'(acc_q), 0);

    // Load the accumulator, stall two beats, then reset asynchronously.
    send(8'h00, 8'h55, 1'b0, 1'b1);
    expect_out("acc55", 8'h55, 1'b0, 0);
    @(negedge clk);
    chk("acc_q_55", 32'(acc_q), 8'h55);
    out_ready = 1'b0;
    send(8'h01, 8'h02, 1'b0, 1'b0);
    send(8'h03, 8'h04, 1'b0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(out_valid), 0);
    chk("async_rst_acc", 32'(acc_q), 0);
    chk("async_rst_sum", 32'(out_sum), 0);
    @(negedge clk);
    rst_n = 1'b1; out_ready = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (out_valid) stale++;
    end
    chk("no_stale_beat", 32'(stale), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
